axis_stream_checker: RTL and testbench

- Downstream AXI4-Stream sink for the signal-generator stage. Consumes its 256-bit packet stream, applies optional pseudo-random backpressure, and checks payload pattern, strobes, tuser and length.
- Exposes saturating statistics and error counters for bring-up of the SRAM output queue datapath.
- Single clock domain: the generator's fabric clock, 160 MHz.

---
 rtl/axis_stream_checker.sv | 161 ++++++++++++++++
 tb/tb_axis_stream_checker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink for the signal-generator stage: optional LFSR backpressure,
// payload/strobe/tuser/length checking and saturating statistics counters.
module axis_stream_checker #(
    parameter int          DATA_WIDTH   = 256,
    parameter int          STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int          USER_WIDTH   = 128,
    parameter int          CNT_WIDTH    = 32,
    parameter int          BACKPRESSURE = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_stats,
    input  logic                  tvalid,
    output logic                  tready,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic [STRB_WIDTH-1:0] tstrb,
    input  logic [USER_WIDTH-1:0] tuser,
    input  logic                  tlast,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic [CNT_WIDTH-1:0]  err_data_count,
    output logic [CNT_WIDTH-1:0]  err_strb_count,
    output logic [CNT_WIDTH-1:0]  err_user_count,
    output logic [CNT_WIDTH-1:0]  err_len_count,
    output logic                  error
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam int BW    = $clog2(STRB_WIDTH + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t               state, state_next;
    logic [15:0]          lfsr;
    logic                 bp_ok, accept;
    logic [CNT_WIDTH-1:0] acc, pkt_bytes;
    logic [31:0]          sop_user, exp_word;
    logic                 locked;
    logic [BW-1:0]        beat_bytes;
    logic [15:0]          ref_len;
    logic                 user_bad, data_bad, strb_bad, len_bad;

    // Events are registered first so counters move one cycle after the beat.
    logic                 ev_pkt, ev_data, ev_strb, ev_user, ev_len;
    logic [CNT_WIDTH-1:0] ev_bytes;

    function automatic logic [BW-1:0] popcount(input logic [STRB_WIDTH-1:0] s);
        logic [BW-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_WIDTH; i++) n = n + BW'(s[i]);
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic e);
        return (e && (c != '1)) ? c + 1'b1 : c;
    endfunction

    assign bp_ok  = (BACKPRESSURE == 0) || (lfsr[1:0] != 2'b00);
    assign accept = tvalid & tready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr   <= LFSR_SEED;
            tready <= 1'b0;
            state  <= IDLE;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tready <= enable & bp_ok;
            state  <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        beat_bytes = popcount(tstrb);
        user_bad   = 1'b0;
        pkt_bytes  = CNT_WIDTH'(beat_bytes);
        ref_len    = tuser[15:0];
        data_bad   = 1'b0;
        if (state == IN_PKT) begin
            user_bad  = (tuser[31:0] != sop_user);
            pkt_bytes = acc + CNT_WIDTH'(beat_bytes);
            ref_len   = sop_user[15:0];
        end
        if (accept) state_next = tlast ? IDLE : IN_PKT;
        len_bad  = (pkt_bytes != CNT_WIDTH'(ref_len));
        // A legal last strobe is 2^n-1: nonzero and no hole above bit 0.
        strb_bad = tlast ? ((tstrb == '0) || ((tstrb & (tstrb + STRB_WIDTH'(1))) != '0))
                         : (tstrb != '1);
        for (int l = 0; l < LANES; l++) begin
            if ((&tstrb[4*l +: 4]) && (tdata[32*l +: 32] != exp_word)) data_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            sop_user <= '0;
        end else if (accept) begin
            acc <= pkt_bytes;
            if (state == IDLE) sop_user <= tuser[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_stats) begin
            locked   <= 1'b0;
            exp_word <= '0;
        end else if (accept) begin
            locked   <= 1'b1;
            exp_word <= (locked && !data_bad) ? exp_word + 32'd1 : tdata[31:0] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_stats) begin
            ev_pkt   <= 1'b0;
            ev_bytes <= '0;
            ev_data  <= 1'b0;
            ev_strb  <= 1'b0;
            ev_user  <= 1'b0;
            ev_len   <= 1'b0;
        end else begin
            ev_pkt   <= accept & tlast;
            ev_bytes <= (accept & tlast) ? pkt_bytes : '0;
            ev_data  <= accept & locked & data_bad;
            ev_strb  <= accept & strb_bad;
            ev_user  <= accept & user_bad;
            ev_len   <= accept & tlast & len_bad;
        end
    end

    logic [CNT_WIDTH:0] byte_sum;
    assign byte_sum = {1'b0, byte_count} + {1'b0, ev_bytes};

    always_ff @(posedge clk) begin
        if (!reset || clear_stats) begin
            pkt_count      <= '0;
            byte_count     <= '0;
            err_data_count <= '0;
            err_strb_count <= '0;
            err_user_count <= '0;
            err_len_count  <= '0;
            error          <= 1'b0;
        end else begin
            pkt_count      <= sat_inc(pkt_count, ev_pkt);
            byte_count     <= byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
            err_data_count <= sat_inc(err_data_count, ev_data);
            err_strb_count <= sat_inc(err_strb_count, ev_strb);
            err_user_count <= sat_inc(err_user_count, ev_user);
            err_len_count  <= sat_inc(err_len_count, ev_len);
            error          <= error | ev_data | ev_strb | ev_user | ev_len;
        end
    end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Self-checking bench for axis_stream_checker: directed test-plan steps followed by
// randomized packets, all compared against a packet-level reference model.
module tb_axis_stream_checker;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          clear_stats = 1'b0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [SW-1:0] tstrb = '0;
    logic [UW-1:0] tuser = '0;

    wire          tready, error;
    wire [CW-1:0] pkt_count, byte_count, err_data_count, err_strb_count, err_user_count, err_len_count;
    wire          tready0, error0;
    wire [CW-1:0] n_pkt, n_bytes, n_data, n_strb, n_user, n_len;

    axis_stream_checker #(.BACKPRESSURE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb), .tuser(tuser),
        .tlast(tlast), .pkt_count(pkt_count), .byte_count(byte_count),
        .err_data_count(err_data_count), .err_strb_count(err_strb_count),
        .err_user_count(err_user_count), .err_len_count(err_len_count), .error(error)
    );

    // Same stimulus without backpressure; only its tready is of interest.
    axis_stream_checker #(.BACKPRESSURE(0)) dut_nobp (
        .clk(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
        .tvalid(tvalid), .tready(tready0), .tdata(tdata), .tstrb(tstrb), .tuser(tuser),
        .tlast(tlast), .pkt_count(n_pkt), .byte_count(n_bytes),
        .err_data_count(n_data), .err_strb_count(n_strb),
        .err_user_count(n_user), .err_len_count(n_len), .error(error0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stalls = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backpressure model: the stated LFSR rule, tready one cycle behind.
    logic [15:0] m_lfsr;
    logic        m_tready, m_tready0;
    always @(posedge clk) begin
        if (!reset) begin
            m_lfsr    <= 16'hACE1;
            m_tready  <= 1'b0;
            m_tready0 <= 1'b0;
        end else begin
            m_lfsr    <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            m_tready  <= enable && (m_lfsr[1:0] != 2'b00);
            m_tready0 <= enable;
        end
    end

    // Packet-level model of the statistics.
    logic [31:0] m_pkt, m_bytes, m_data, m_strb, m_user, m_len;
    bit          m_err, m_locked, m_inpkt;
    logic [31:0] m_exp, m_sop;
    int          m_acc;

    function automatic logic [31:0] sinc(input logic [31:0] c, input bit e);
        return (e && c != 32'hFFFF_FFFF) ? c + 1 : c;
    endfunction

    task automatic model_zero();
        m_pkt = 0; m_bytes = 0; m_data = 0; m_strb = 0; m_user = 0; m_len = 0;
        m_err = 0; m_locked = 0;
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                              input logic [31:0] u, input bit last, input bit clr);
        bit e_user, e_strb, e_data, e_len;
        int n;
        logic [SW-1:0] mask;
        logic [33:0] sum;
        e_user = 0; e_data = 0; e_len = 0;
        if (!m_inpkt) begin
            m_sop = u;
            m_acc = 0;
        end else if (u != m_sop) e_user = 1;
        n = $countones(s);
        m_acc += n;
        mask = (n == SW) ? '1 : ((SW'(1) << n) - 1);
        e_strb = last ? (n == 0 || s != mask) : (s != '1);
        if (m_locked) begin
            for (int l = 0; l < DW / 32; l++)
                if (s[4*l +: 4] == 4'hF && d[32*l +: 32] != m_exp) e_data = 1;
            m_exp = e_data ? d[31:0] + 1 : m_exp + 1;
        end else begin
            m_exp = d[31:0] + 1;
        end
        m_locked = 1;
        if (last) e_len = (m_acc != int'(m_sop[15:0]));
        m_inpkt = !last;
        if (clr) begin
            model_zero();
        end else begin
            if (last) begin
                m_pkt = sinc(m_pkt, 1);
                sum = {2'b0, m_bytes} + 34'(m_acc);
                m_bytes = (sum > 34'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            end
            m_data = sinc(m_data, e_data);
            m_strb = sinc(m_strb, e_strb);
            m_user = sinc(m_user, e_user);
            m_len  = sinc(m_len, e_len);
            m_err  = m_err | e_data | e_strb | e_user | e_len;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("tready", tready, m_tready);
        check("tready_nobp", tready0, m_tready0);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pkt"},  pkt_count, m_pkt);
        check({tag, ".bytes"}, byte_count, m_bytes);
        check({tag, ".edata"}, err_data_count, m_data);
        check({tag, ".estrb"}, err_strb_count, m_strb);
        check({tag, ".euser"}, err_user_count, m_user);
        check({tag, ".elen"},  err_len_count, m_len);
        check({tag, ".error"}, error, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tvalid = 1'b0;
        repeat (3) tick();
        model_zero();
        m_inpkt = 0;
        m_acc = 0;
        reset = 1'b1;
    endtask

    task automatic send_beat(input logic [31:0] w, input int lane_bad, input logic [SW-1:0] s,
                             input logic [31:0] u, input bit last, input bit clr);
        int budget;
        tdata = {(DW / 32){w}};
        if (lane_bad >= 0) tdata[lane_bad*32 +: 32] = ~w;
        tstrb = s;
        tuser = UW'(u);
        tlast = last;
        tvalid = 1'b1;
        clear_stats = clr;
        budget = 0;
        while (!tready && budget < 200) begin
            tick();
            stalls++;
            budget++;
        end
        check("accept_timeout", (budget < 200), 1);
        if (budget < 200) begin
            @(posedge clk);
            model_beat(tdata, s, u, last, clr);
            tick();
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        clear_stats = 1'b0;
    endtask

    logic [31:0] word;

    task automatic send_pkt(input int nb, input logic [SW-1:0] last_s, input logic [31:0] u);
        for (int b = 0; b < nb; b++) begin
            send_beat(word, -1, (b == nb - 1) ? last_s : '1, u, b == nb - 1, 0);
            word++;
        end
    endtask

    initial begin
        int nb, n, bad_lane;
        logic [SW-1:0] lastm;
        logic [31:0] u, ub;
        logic [15:0] len;

        m_inpkt = 0; m_acc = 0; m_exp = 0; m_sop = 0;
        model_zero();
        do_reset();
        check("reset.tready", tready, 0);
        compare_all("reset");
        check("reset.pkt_const", pkt_count, 0);
        enable = 1'b1;
        repeat (2) tick();

        // 64 B packet, words 0,1; counters must lag the last beat by one cycle.
        word = 0;
        send_beat(word, -1, '1, 32'd64, 0, 0); word++;
        send_beat(word, -1, '1, 32'd64, 1, 0); word++;
        check("latency.pkt", pkt_count, 0);
        tick();
        check("p64.pkt", pkt_count, 1);
        check("p64.bytes", byte_count, 64);
        compare_all("p64");

        send_pkt(3, 32'h3F, 32'd70);
        tick();
        check("p70.bytes", byte_count, 134);
        compare_all("p70");

        // Lane 5 corrupted on the third of four beats.
        for (int b = 0; b < 4; b++) begin
            send_beat(word, (b == 2) ? 5 : -1, '1, 32'd128, b == 3, 0);
            word++;
        end
        tick();
        check("corrupt.edata", err_data_count, 1);
        check("corrupt.error", error, 1);
        compare_all("corrupt");

        send_pkt(3, '1, 32'd100);
        tick();
        check("len.elen", err_len_count, 1);
        compare_all("len");

        send_pkt(2, 32'h0000_00F0, 32'd36);
        tick();
        check("strb.estrb", err_strb_count, 1);
        compare_all("strb");

        send_beat(word, -1, '1, 32'h0001_0040, 0, 0); word++;
        send_beat(word, -1, '1, 32'h0002_0040, 1, 0); word++;
        tick();
        check("user.euser", err_user_count, 1);
        compare_all("user");

        // enable dropped mid-packet: state is held.
        send_beat(word, -1, '1, 32'd64, 0, 0); word++;
        enable = 1'b0;
        repeat (6) tick();
        enable = 1'b1;
        send_beat(word, -1, '1, 32'd64, 1, 0); word++;
        tick();
        compare_all("hold");

        // Reset mid-packet discards the partial packet.
        send_beat(word, -1, '1, 32'd64, 0, 0); word++;
        do_reset();
        enable = 1'b1;
        send_pkt(2, '1, 32'd64);
        tick();
        check("rstmid.pkt", pkt_count, 1);
        compare_all("rstmid");

        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        model_zero();
        tick();
        compare_all("clear");

        stalls = 0;
        for (int p = 0; p < 100; p++) send_pkt(2, '1, 32'd64);
        tick();
        check("bp.pkt", pkt_count, 100);
        check("bp.bytes", byte_count, 6400);
        check("bp.stalled", stalls > 0, 1);
        compare_all("bp");

        // clear_stats in the same cycle as the tlast acceptance.
        send_beat(word, -1, '1, 32'd64, 0, 0); word++;
        send_beat(word, -1, '1, 32'd64, 1, 1); word++;
        repeat (2) tick();
        check("clrlast.pkt", pkt_count, 0);
        check("clrlast.bytes", byte_count, 0);
        compare_all("clrlast");

        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 4);
            n = $urandom_range(1, 32);
            lastm = (n == 32) ? '1 : ((SW'(1) << n) - 1);
            if ($urandom_range(0, 9) == 0) lastm = 32'h0000_0F0F;
            len = 16'((nb - 1) * 32 + $countones(lastm));
            if ($urandom_range(0, 7) == 0) len = len + 16'd1;
            u = {8'($urandom), 8'($urandom), len};
            for (int b = 0; b < nb; b++) begin
                bad_lane = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
                ub = u;
                if (b > 0 && $urandom_range(0, 9) == 0) ub = ub ^ 32'h0001_0000;
                send_beat(word, bad_lane, (b == nb - 1) ? lastm : '1, ub, b == nb - 1, 0);
                word++;
                if (b < nb - 1 && $urandom_range(0, 4) == 0) begin
                    enable = 1'b0;
                    repeat (3) tick();
                    enable = 1'b1;
                end
            end
            tick();
            compare_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
